// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths and entry layout for the reorder buffer
package rob_pkg;

  localparam int WIDTH     = 31;
  localparam int ROB       = 2;
  localparam int CONTROL   = 5;
  localparam int REG       = 4;
  localparam int ROB_DEPTH = 2 ** (ROB + 1);

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [REG:0]       destReg;
    logic [WIDTH:0]     value;
    logic               isControl;
    logic [WIDTH:0]     target;
    logic [CONTROL:0]   pcControl;
  } rob_entry_t;

endpackage

// File: rtl/rob_pointer.sv
// rtl/rob_pointer.sv - wrapping ring pointer with increment and clear
module rob_pointer
  import rob_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [ROB:0] o_ptr
);

  logic [ROB:0] r_ptr;

  // Clear wins over increment so a flush always lands the pointer on slot 0.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order ROB: allocate, CDB mark-ready, retire, flush
module reorder_buffer
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             allocValid,
  input  logic [REG:0]     allocDestReg,
  output logic [ROB:0]     allocEntry,
  output logic             robFull,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbRobEntry,
  input  logic [WIDTH:0]   cdbResult,
  input  logic             cdbIsControl,
  input  logic [WIDTH:0]   cdbTargetAddress,
  input  logic [CONTROL:0] cdbPcControl,
  input  logic [ROB:0]     src1Entry,
  input  logic [ROB:0]     src2Entry,
  output logic             src1Ready,
  output logic             src2Ready,
  output logic [WIDTH:0]   src1Value,
  output logic [WIDTH:0]   src2Value,
  output logic             commitValid,
  output logic [REG:0]     commitDestReg,
  output logic [WIDTH:0]   commitValue,
  output logic [ROB:0]     commitEntry,
  output logic [CONTROL:0] commitPcControl,
  output logic             flush,
  output logic [WIDTH:0]   redirectPc
);

  rob_entry_t       r_entries [ROB_DEPTH];
  logic [ROB+1:0]   r_count;
  logic             r_commit_valid;
  logic [REG:0]     r_commit_dest;
  logic [WIDTH:0]   r_commit_value;
  logic [ROB:0]     r_commit_entry;
  logic [CONTROL:0] r_commit_pcc;
  logic             r_flush;
  logic [WIDTH:0]   r_redirect_pc;

  logic [ROB:0]     w_head;
  logic [ROB:0]     w_tail;
  rob_entry_t       w_head_entry;
  rob_entry_t       w_new_entry;
  logic             w_full;
  logic             w_retire;
  logic             w_mispredict;
  logic             w_alloc;
  logic             w_cdb_wr;

  rob_pointer u_head (.clk(clk), .reset(reset), .i_inc(w_retire), .i_clr(w_mispredict), .o_ptr(w_head));
  rob_pointer u_tail (.clk(clk), .reset(reset), .i_inc(w_alloc),  .i_clr(w_mispredict), .o_ptr(w_tail));

  // Fullness comes from registered count only; a same-cycle retire does not free a slot.
  assign w_full       = (r_count == (ROB + 2)'(ROB_DEPTH));
  assign w_head_entry = r_entries[w_head];
  assign w_retire     = w_head_entry.valid & w_head_entry.ready;
  assign w_mispredict = w_retire & w_head_entry.isControl & w_head_entry.pcControl[0];
  assign w_alloc      = allocValid & ~w_full & ~r_flush & ~w_mispredict;
  assign w_cdb_wr     = cdbValid & r_entries[cdbRobEntry].valid & ~r_flush;

  always_comb begin
    w_new_entry         = '0;
    w_new_entry.valid   = 1'b1;
    w_new_entry.destReg = allocDestReg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_count        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_dest  <= '0;
      r_commit_value <= '0;
      r_commit_entry <= '0;
      r_commit_pcc   <= '0;
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_commit_valid <= w_retire;
      r_flush        <= w_mispredict;
      if (w_retire) begin
        r_commit_dest  <= w_head_entry.destReg;
        r_commit_value <= w_head_entry.value;
        r_commit_entry <= w_head;
        r_commit_pcc   <= w_head_entry.pcControl;
      end
      if (w_mispredict) begin
        r_redirect_pc <= w_head_entry.target;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          r_entries[i].valid <= 1'b0;
          r_entries[i].ready <= 1'b0;
        end
        r_count <= '0;
      end else begin
        if (w_cdb_wr) begin
          r_entries[cdbRobEntry].ready     <= 1'b1;
          r_entries[cdbRobEntry].value     <= cdbResult;
          r_entries[cdbRobEntry].isControl <= cdbIsControl;
          r_entries[cdbRobEntry].pcControl <= cdbPcControl;
          if (cdbIsControl) begin
            r_entries[cdbRobEntry].target <= cdbTargetAddress;
          end
        end
        if (w_retire) begin
          r_entries[w_head].valid <= 1'b0;
        end
        if (w_alloc) begin
          r_entries[w_tail] <= w_new_entry;
        end
        case ({w_alloc, w_retire})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Operand lookup: a broadcast this cycle takes priority over the stored value.
  always_comb begin
    src1Ready = (cdbValid && cdbRobEntry == src1Entry) ||
                (r_entries[src1Entry].valid && r_entries[src1Entry].ready);
    src2Ready = (cdbValid && cdbRobEntry == src2Entry) ||
                (r_entries[src2Entry].valid && r_entries[src2Entry].ready);
    src1Value = '0;
    src2Value = '0;
    if (cdbValid && cdbRobEntry == src1Entry) begin
      src1Value = cdbResult;
    end else if (r_entries[src1Entry].valid && r_entries[src1Entry].ready) begin
      src1Value = r_entries[src1Entry].value;
    end
    if (cdbValid && cdbRobEntry == src2Entry) begin
      src2Value = cdbResult;
    end else if (r_entries[src2Entry].valid && r_entries[src2Entry].ready) begin
      src2Value = r_entries[src2Entry].value;
    end
  end

  assign allocEntry      = w_tail;
  assign robFull         = w_full;
  assign commitValid     = r_commit_valid;
  assign commitDestReg   = r_commit_dest;
  assign commitValue     = r_commit_value;
  assign commitEntry     = r_commit_entry;
  assign commitPcControl = r_commit_pcc;
  assign flush           = r_flush;
  assign redirectPc      = r_redirect_pc;

endmodule
